// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, FSM state encoding and total-period helpers for the
// RGB panel frame scheduler.
package lcd_timing_pkg;

  localparam int DEF_H_PW  = 20;
  localparam int DEF_H_BP  = 80;
  localparam int DEF_H_ACT = 1600;
  localparam int DEF_H_FP  = 40;
  localparam int DEF_V_PW  = 2;
  localparam int DEF_V_BP  = 20;
  localparam int DEF_V_ACT = 480;
  localparam int DEF_V_FP  = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  function automatic int calc_ht(input int pw, input int bp, input int act, input int fp);
    return pw + bp + act + fp;
  endfunction

  function automatic int calc_vt(input int pw, input int bp, input int act, input int fp);
    return pw + bp + act + fp;
  endfunction

endpackage

// File: rtl/lcd_hv_counter.sv
// Horizontal/vertical position counter pair. clr wins over en; frame_end flags
// the last line, so the frame wrap cycle is line_end & frame_end.
module lcd_hv_counter
  import lcd_timing_pkg::*;
#(
  parameter int HT = calc_ht(DEF_H_PW, DEF_H_BP, DEF_H_ACT, DEF_H_FP),
  parameter int VT = calc_vt(DEF_V_PW, DEF_V_BP, DEF_V_ACT, DEF_V_FP)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] hcnt,
  output logic [15:0] vcnt,
  output logic        line_end,
  output logic        frame_end
);

  localparam logic [15:0] H_LAST = 16'(HT - 1);
  localparam logic [15:0] V_LAST = 16'(VT - 1);

  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] vcnt_q, vcnt_d;

  assign hcnt      = hcnt_q;
  assign vcnt      = vcnt_q;
  assign line_end  = (hcnt_q == H_LAST);
  assign frame_end = (vcnt_q == V_LAST);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (clr) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (en) begin
      if (line_end) begin
        hcnt_d = '0;
        vcnt_d = frame_end ? 16'd0 : vcnt_q + 16'd1;
      end else begin
        hcnt_d = hcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/lcd_frame_sched.sv
// Frame scheduler: producer line/frame strobes, FIFO pop, panel bus and
// underflow recovery. Define LCD_UNDERFLOW_CNT_EN to add the UF_COUNT output.
module lcd_frame_sched
  import lcd_timing_pkg::*;
#(
  parameter int H_PW     = DEF_H_PW,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_PW     = DEF_V_PW,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        FIFOEmpty,
  input  logic [7:0]  FIFOData,
  output logic        FIFORe,
  output logic        FIFOFlush,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        LCD_HS,
  output logic        LCD_VS,
  output logic        LCD_DE,
  output logic [7:0]  LCD_DATA,
  output logic        UNDERFLOW
`ifdef LCD_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] UF_COUNT
`endif
);

  localparam int HT = calc_ht(H_PW, H_BP, H_ACT, H_FP);
  localparam int VT = calc_vt(V_PW, V_BP, V_ACT, V_FP);

  localparam logic [15:0] H_SYNC_END = 16'(H_PW);
  localparam logic [15:0] V_SYNC_END = 16'(V_PW);
  localparam logic [15:0] H_ACT_BEG  = 16'(H_PW + H_BP);
  localparam logic [15:0] H_ACT_END  = 16'(H_PW + H_BP + H_ACT);
  localparam logic [15:0] V_ACT_BEG  = 16'(V_PW + V_BP);
  localparam logic [15:0] V_ACT_END  = 16'(V_PW + V_BP + V_ACT);
  // Producer frame window runs one line ahead of the panel active window.
  localparam logic [15:0] V_PRE_BEG  = 16'(V_PW + V_BP - 1);
  localparam logic [15:0] V_PRE_END  = 16'(V_PW + V_BP + V_ACT - 1);

  state_e      state_q, state_d;
  logic        uf_q, uf_d;
  logic        flush_q, flush_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        rd_vld_q, rd_vld_d;

  logic [15:0] hcnt, vcnt;
  logic        line_end, last_line, wrap;
  logic        running, hs, vs, hact, vact, uflow;

  lcd_hv_counter #(.HT(HT), .VT(VT)) u_hv (
    .clk       (CLK),
    .rst       (RST),
    .en        (running),
    .clr       (~ENABLE),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .line_end  (line_end),
    .frame_end (last_line)
  );

  assign running = (state_q != ST_IDLE);
  assign wrap    = line_end & last_line;
  assign hs      = (hcnt < H_SYNC_END);
  assign vs      = (vcnt < V_SYNC_END);
  assign hact    = (hcnt >= H_ACT_BEG) && (hcnt < H_ACT_END);
  assign vact    = (vcnt >= V_ACT_BEG) && (vcnt < V_ACT_END);
  assign FIFORe  = (state_q == ST_RUN) & hact & vact;
  assign uflow   = FIFORe & FIFOEmpty;

  assign HSYNC     = ~running | hs;
  assign VSYNC     = ~running | ~((vcnt >= V_PRE_BEG) && (vcnt < V_PRE_END));
  assign FIFOFlush = flush_q;
  assign UNDERFLOW = uf_q;
  assign LCD_HS    = hs_q ? SYNC_POL : ~SYNC_POL;
  assign LCD_VS    = vs_q ? SYNC_POL : ~SYNC_POL;
  assign LCD_DE    = de_q;
  assign LCD_DATA  = rd_vld_q ? FIFOData : 8'h00;

  always_comb begin
    state_d  = state_q;
    uf_d     = uf_q;
    flush_d  = 1'b0;
    hs_d     = 1'b0;
    vs_d     = 1'b0;
    de_d     = 1'b0;
    rd_vld_d = 1'b0;
    if (!ENABLE) begin
      state_d = ST_IDLE;
      uf_d    = 1'b0;
      flush_d = running;
    end else begin
      hs_d     = running & hs;
      vs_d     = running & vs;
      de_d     = running & hact & vact;
      rd_vld_d = FIFORe & ~FIFOEmpty;
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (uflow) begin
            state_d = ST_RECOVER;
            uf_d    = 1'b1;
          end
        end
        ST_RECOVER: begin
          if (wrap) begin
            state_d = ST_RUN;
            flush_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      uf_q     <= 1'b0;
      flush_q  <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      de_q     <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      uf_q     <= uf_d;
      flush_q  <= flush_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      rd_vld_q <= rd_vld_d;
    end
  end

`ifdef LCD_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  assign UF_COUNT = uf_cnt_q;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (ENABLE && (state_q == ST_RUN) && uflow && (uf_cnt_q != 16'hFFFF))
      uf_cnt_d = uf_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) uf_cnt_q <= '0;
    else     uf_cnt_q <= uf_cnt_d;
  end
`endif

endmodule
